ysyx_23060240_sram: RTL and testbench

- AXI4-Lite slave SRAM model downstream of the IFU/LSU arbiter; consumes the arbiter's single shared master port (saxi_* side).
- Word-organised memory array with byte write strobes.
- Independent read and write FSMs, with a programmable access latency to emulate slow memory.
- No response-code channels (no rresp/bresp), matching the arbiter's port set.

---
 rtl/ysyx_23060240_axi_pkg.sv | 34 +++
 rtl/ysyx_23060240_lat_cnt.sv | 41 ++++
 rtl/ysyx_23060240_sram.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ysyx_23060240_sram.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_axi_pkg
// Shared types and constants for the AXI4-Lite SRAM slave.
//   rd_state_e / wr_state_e : read and write FSM encodings
//   SRAM_BASE_DEFAULT       : default byte address of word 0
//   LFSR_SEED / LFSR_TAPS   : Galois LFSR used when SRAM_RAND_DELAY_EN is
//                             defined (polynomial x^8+x^6+x^5+x^4+1)
//   lfsr_next()             : one right-shifting Galois LFSR step
// ---------------------------------------------------------------------------
package ysyx_23060240_axi_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   localparam logic [31:0] SRAM_BASE_DEFAULT = 32'h8000_0000;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Toggle mask for x^8+x^6+x^5+x^4+1 in right-shift Galois form.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      lfsr_next = {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/ysyx_23060240_lat_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_lat_cnt
// Wait-cycle counter shared by the read and write paths of the SRAM.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : number of wait cycles to spend before done_o
//   done_o       : high during the last wait cycle (count == 1)
// The counter decrements to zero and parks there until the next load.
// ---------------------------------------------------------------------------
module ysyx_23060240_lat_cnt
   import ysyx_23060240_axi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic       done_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/ysyx_23060240_sram.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_sram
// AXI4-Lite slave SRAM model with byte strobes and emulated access latency.
// Read and write FSMs are independent; no response-code channels.
//
// Parameters: BASE (byte address of word 0), AW (log2 words), LATENCY (0..15)
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   araddr/arvalid/arready        : read address channel
//   rdata/rvalid/rready           : read data channel
//   awaddr/awvalid/awready        : write address channel
//   wdata/wstrb/wvalid/wready     : write data channel
//   bvalid/bready                 : write response channel
//
// Handshake: a beat transfers on the rising edge where valid && ready are
// both high. All outputs come from registered state only; rvalid and bvalid
// stay high until accepted, and rdata is stable while rvalid is high.
//
// Optional macro SRAM_RAND_DELAY_EN: wait count per transaction comes from
// an 8-bit Galois LFSR (lfsr[2:0]+1, i.e. 1..8) and LATENCY is ignored.
// ---------------------------------------------------------------------------
module ysyx_23060240_sram
   import ysyx_23060240_axi_pkg::*;
#(
   parameter logic [31:0] BASE    = SRAM_BASE_DEFAULT,
   parameter int          AW      = 12,
   parameter int          LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] SPAN  = 32'(4 << AW);

   logic [31:0] mem_q [DEPTH];

   // Unsigned offset compare also rejects addresses below BASE (wraparound).
   function automatic logic in_range(input logic [31:0] a);
      return (a - BASE) < SPAN;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return AW'((a - BASE) >> 2);
   endfunction

   // ---------------- wait-count source ----------------
   logic [3:0] lat_val;
   logic       zero_lat;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign lat_val = {1'b0, lfsr_q[2:0]} + 4'd1;
`else
   assign lat_val = 4'(LATENCY);
`endif

   assign zero_lat = (lat_val == 4'd0);

   // ---------------- read path ----------------
   rd_state_e   rd_state_q, rd_state_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_addr;
   logic        rd_load, rd_done, rd_capture;

   ysyx_23060240_lat_cnt u_rd_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rd_load),
      .load_val_i (lat_val),
      .done_o     (rd_done)
   );

   always_comb begin
      rd_state_d = rd_state_q;
      ar_addr_d  = ar_addr_q;
      rd_addr    = ar_addr_q;
      rd_load    = 1'b0;
      rd_capture = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (arvalid) begin
               ar_addr_d = araddr;
               // With zero latency the array is read before ar_addr_q is written.
               rd_addr   = araddr;
               if (zero_lat) begin
                  rd_capture = 1'b1;
                  rd_state_d = R_DATA;
               end else begin
                  rd_load    = 1'b1;
                  rd_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (rd_done) begin
               rd_capture = 1'b1;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rready) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_capture) begin
         rdata_d = in_range(rd_addr) ? mem_q[word_idx(rd_addr)] : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         ar_addr_q  <= 32'h0;
         rdata_q    <= 32'h0;
      end else begin
         rd_state_q <= rd_state_d;
         ar_addr_q  <= ar_addr_d;
         rdata_q    <= rdata_d;
      end
   end

   assign arready = (rd_state_q == R_IDLE);
   assign rvalid  = (rd_state_q == R_DATA);
   assign rdata   = rdata_q;

   // ---------------- write path ----------------
   wr_state_e   wr_state_q, wr_state_d;
   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_fire, w_fire;
   logic        wr_load, wr_done, wr_commit;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;

   ysyx_23060240_lat_cnt u_wr_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (wr_load),
      .load_val_i (lat_val),
      .done_o     (wr_done)
   );

   assign awready = (wr_state_q == W_IDLE) && !aw_held_q;
   assign wready  = (wr_state_q == W_IDLE) && !w_held_q;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   // A zero-latency commit can happen on the same edge the last beat arrives,
   // so take whichever of held/incoming is current.
   assign wr_addr = aw_held_q ? aw_addr_q : awaddr;
   assign wr_data = w_held_q  ? wdata_q   : wdata;
   assign wr_strb = w_held_q  ? wstrb_q   : wstrb;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_addr_d  = aw_addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wr_load    = 1'b0;
      wr_commit  = 1'b0;
      if (aw_fire) begin
         aw_held_d = 1'b1;
         aw_addr_d = awaddr;
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
      end
      case (wr_state_q)
         W_IDLE: begin
            if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
               if (zero_lat) begin
                  wr_commit  = 1'b1;
                  wr_state_d = W_RESP;
               end else begin
                  wr_load    = 1'b1;
                  wr_state_d = W_WAIT;
               end
            end
         end
         W_WAIT: begin
            if (wr_done) begin
               wr_commit  = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bready) begin
               wr_state_d = W_IDLE;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_addr_q  <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_addr_q  <= aw_addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
      end
   end

   // Array is not reset. A commit landing on a reset edge is dropped, and a
   // read capturing on the same edge as a commit sees the old word.
   always_ff @(posedge clk) begin
      if (!rst && wr_commit && in_range(wr_addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
               mem_q[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign bvalid = (wr_state_q == W_RESP);

endmodule

// File: tb/tb_ysyx_23060240_sram.sv
module tb_ysyx_23060240_sram;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          LAT  = 1;
   localparam logic [31:0] SPAN = 32'h0000_4000;  // 4096 words * 4 bytes

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic        bvalid;
   logic        bready = 1'b0;

   ysyx_23060240_sram #(.BASE(BASE), .AW(12), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      int unsigned hs;
   } rd_exp_t;

   rd_exp_t     rd_exp_q[$];
   int unsigned wr_exp_q[$];
   logic [31:0] model_mem [4096];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      return (a - BASE) < SPAN;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      return m_hit(a) ? model_mem[m_idx(a)] : 32'h0;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (m_hit(a)) begin
         w = model_mem[m_idx(a)];
         for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         model_mem[m_idx(a)] = w;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] oor [4];
      oor[0] = BASE - 32'd4;
      oor[1] = BASE + SPAN;
      oor[2] = 32'h0;
      oor[3] = 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) return oor[$urandom_range(0, 3)];
      return BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
   endfunction

   // ---------------- compare process ----------------
   bit rvalid_prev = 1'b0;
   bit bvalid_prev = 1'b0;

   always @(negedge clk) begin
      int unsigned lat;
      if (rst) begin
         rvalid_prev = 1'b0;
         bvalid_prev = 1'b0;
      end else begin
         if (rvalid) begin
            if (rd_exp_q.size() == 0) begin
               chk("rvalid_unexpected", {31'b0, rvalid}, 32'd0);
            end else begin
               if (!rvalid_prev) begin
                  lat = cyc - rd_exp_q[0].hs;
`ifdef SRAM_RAND_DELAY_EN
                  chk("r_latency_2_to_9", {31'b0, (lat >= 2 && lat <= 9)}, 32'd1);
`else
                  chk("r_latency", lat, LAT + 1);
`endif
               end
               chk("rdata", rdata, rd_exp_q[0].data);
               chk("arready_low_in_rdata", {31'b0, arready}, 32'd0);
               if (rready) void'(rd_exp_q.pop_front());
            end
         end
         rvalid_prev = rvalid && !rready;

         if (bvalid) begin
            if (wr_exp_q.size() == 0) begin
               chk("bvalid_unexpected", {31'b0, bvalid}, 32'd0);
            end else begin
               if (!bvalid_prev) begin
                  lat = cyc - wr_exp_q[0];
`ifdef SRAM_RAND_DELAY_EN
                  chk("b_latency_2_to_9", {31'b0, (lat >= 2 && lat <= 9)}, 32'd1);
`else
                  chk("b_latency", lat, LAT + 1);
`endif
               end
               chk("awready_low_in_resp", {31'b0, awready}, 32'd0);
               chk("wready_low_in_resp", {31'b0, wready}, 32'd0);
               if (bready) void'(wr_exp_q.pop_front());
            end
         end
         bvalid_prev = bvalid && !bready;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_read(input logic [31:0] a, input int rready_dly, output logic [31:0] got);
      bit hs_done, done;
      int nv;
      hs_done = 1'b0; done = 1'b0; nv = 0; got = 32'hx;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      for (int t = 0; t < 64 && !hs_done; t++) begin
         @(negedge clk);
         if (arready) begin
            hs_done = 1'b1;
            rd_exp_q.push_back('{data: m_read(a), hs: cyc});
         end
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      chk("ar_handshake", {31'b0, hs_done}, 32'd1);
      if (!hs_done) return;
      for (int t = 0; t < 64 && !done; t++) begin
         rready = (nv >= rready_dly);
         @(negedge clk);
         if (rvalid) begin
            got = rdata;
            if (rready) done = 1'b1;
            nv++;
         end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      chk("r_handshake", {31'b0, done}, 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done, w_done, b_done;
      int unsigned hs;
      int nb;
      aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; hs = 0; nb = 0;
      awaddr = a; wdata = d; wstrb = s;
      for (int t = 0; t < 64 && !(aw_done && w_done); t++) begin
         awvalid = !aw_done && (t >= aw_dly);
         wvalid  = !w_done && (t >= w_dly);
         @(negedge clk);
         if (w_done && !aw_done) begin
            chk("wready_low_after_w", {31'b0, wready}, 32'd0);
            chk("awready_high_waiting", {31'b0, awready}, 32'd1);
         end
         if (awvalid && awready) begin aw_done = 1'b1; hs = cyc; end
         if (wvalid && wready)   begin w_done = 1'b1;  hs = cyc; end
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("aw_w_handshake", {31'b0, (aw_done && w_done)}, 32'd1);
      if (!(aw_done && w_done)) return;
      m_write(a, d, s);
      wr_exp_q.push_back(hs);
      for (int t = 0; t < 64 && !b_done; t++) begin
         bready = (nb >= b_dly);
         @(negedge clk);
         if (bvalid) begin
            if (bready) b_done = 1'b1;
            nb++;
         end
         @(posedge clk); #1;
      end
      bready = 1'b0;
      chk("b_handshake", {31'b0, b_done}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_arready"}, {31'b0, arready}, 32'd1);
      chk({tag, "_awready"}, {31'b0, awready}, 32'd1);
      chk({tag, "_wready"},  {31'b0, wready},  32'd1);
      chk({tag, "_rvalid"},  {31'b0, rvalid},  32'd0);
      chk({tag, "_bvalid"},  {31'b0, bvalid},  32'd0);
      chk({tag, "_rdata"},   rdata,            32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] got;
      for (int i = 0; i < 4096; i++) begin
         dut.mem_q[i] = 32'h0;
         model_mem[i] = 32'h0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk); #1;

      // Word 0: zero-initialised, then backdoor-preloaded.
      do_read(BASE, 0, got);
      chk("read_word0_init", got, 32'h0);
      dut.mem_q[0] = 32'hDEAD_BEEF;
      model_mem[0] = 32'hDEAD_BEEF;
      do_read(BASE, 0, got);
      chk("read_word0_preload", got, 32'hDEAD_BEEF);

      // Full write then partial strobed write.
      do_write(BASE + 32'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
      do_write(BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
      do_read(BASE + 32'h10, 0, got);
      chk("read_strobed_merge", got, 32'h12BB_56DD);

      // W leads AW by 3 cycles, then AW leads W by 2.
      do_write(BASE + 32'h20, 32'h0BAD_F00D, 4'hF, 3, 0, 1);
      do_write(BASE + 32'h24, 32'h5555_AAAA, 4'hF, 0, 2, 0);
      do_read(BASE + 32'h20, 0, got);
      chk("read_w_first", got, 32'h0BAD_F00D);

      // Backpressure: rready held low for 5 cycles of rvalid.
      do_read(BASE + 32'h13, 5, got);
      chk("read_backpressure", got, 32'h12BB_56DD);

      // Out-of-range accesses.
      do_read(32'h7FFF_FFFC, 0, got);
      chk("read_out_of_range", got, 32'h0);
      do_write(32'h8001_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      do_read(BASE, 0, got);
      chk("word0_after_oor_write", got, 32'hDEAD_BEEF);

      // Reset while both paths are in their wait state.
      araddr = BASE + 32'h20; arvalid = 1'b1;
      awaddr = BASE + 32'h10; awvalid = 1'b1;
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      chk("pre_reset_arready", {31'b0, arready}, 32'd1);
      chk("pre_reset_awready", {31'b0, awready}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("midreset");
      @(posedge clk); #1;
      do_read(BASE + 32'h10, 0, got);
      chk("write_discarded_by_reset", got, 32'h12BB_56DD);

      // Randomised traffic against the model.
      for (int i = 0; i < 100; i++) begin
         do_read(rand_addr(), $urandom_range(0, 2), got);
      end
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         end else begin
            do_read(rand_addr(), $urandom_range(0, 3), got);
         end
      end

      repeat (3) @(posedge clk);
      chk("rd_queue_drained", rd_exp_q.size(), 32'd0);
      chk("wr_queue_drained", wr_exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
